// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Conditions one raw mechanical push-button for the system clock domain.
// The pad signal is brought in through a two-flop synchroniser, then a
// four-state stable-time filter accepts a new level only after
// STABLE_CYCLES consecutive identical synchronised samples. Accepted
// transitions produce a clean level and single-cycle press/release strobes.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a level (>= 2)
//   CNT_W          filter counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   btn_raw        raw pad input, asynchronous to clk, 1 = pressed
//   btn_level      debounced level (registered)
//   press_pulse    one-cycle strobe on accepted 0->1 (registered)
//   release_pulse  one-cycle strobe on accepted 1->0 (registered)
//   busy           high while a candidate transition is being filtered
//                  (registered)
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  // Last count value before acceptance; the counter never goes past it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_PRESS_CHECK   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_RELEASE_CHECK = 2'd3
  } state_t;

  // Synchroniser stages; only s2_q is used by the filter.
  logic s1_q;
  logic s2_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q,   rel_d;
  logic             busy_q,  busy_d;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Filter state, counter and all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RELEASED;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter and output decode for the stable-time filter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        level_d = 1'b0;
        if (s2_q) begin
          // The first differing sample already counts as sample one.
          state_d = ST_PRESS_CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      ST_PRESS_CHECK: begin
        if (s2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          // A single opposite sample drops back to the stable state.
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_PRESSED: begin
        level_d = 1'b1;
        if (!s2_q) begin
          state_d = ST_RELEASE_CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      ST_RELEASE_CHECK: begin
        if (!s2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            level_d = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d == ST_PRESS_CHECK) || (state_d == ST_RELEASE_CHECK);
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, busy;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .busy(busy)
  );

  typedef struct packed {
    logic rst;
    logic raw;
    logic lvl;
    logic prs;
    logic rel;
    logic bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic raw,
                     input logic lvl, input logic prs, input logic rel, input logic bsy);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.bsy = bsy;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s lvl/prs/rel/bsy got %b want %b", name, got, want);
    end
  endtask

  initial begin
    int n_edges;
    bit seen;

    // Reset held with the button down, then released: new press accepted.
    add(3, 1, 1, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0);
    add(7, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 0);
    add(5, 0, 1, 1, 0, 0, 0);
    // Clean release.
    add(2, 0, 0, 1, 0, 0, 0);
    add(7, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0);
    add(5, 0, 0, 0, 0, 0, 0);
    // Bounce: 1x5, 0x1, 1x2, 0x1, then steady 1.
    add(2, 0, 1, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0);
    add(7, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 0);
    add(4, 0, 1, 1, 0, 0, 0);
    // Release filtering: 0x3, 1x1, then steady 0.
    add(2, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0);
    add(7, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0);
    add(4, 0, 0, 0, 0, 0, 0);
    // Width threshold: high 7 cycles -> rejected.
    add(2, 0, 1, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 1);
    add(4, 0, 0, 0, 0, 0, 0);
    // High 8 cycles -> press, then release 8 cycles later.
    add(2, 0, 1, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0);
    add(7, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    // Reset on an edge while cnt=5, then restart from scratch.
    add(2, 0, 1, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 1);
    add(2, 1, 1, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0);
    add(7, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 0);
    add(2, 0, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      btn_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i),
            {btn_level, press_pulse, release_pulse, busy},
            {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].bsy});
    end

    // Hand sequence: asynchronous reset between edges while cnt=5.
    rst = 1'b1; btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    btn_raw = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("pre_async_rst", {btn_level, press_pulse, release_pulse, busy}, 4'b0001);
    #4 rst = 1'b1;
    #1;
    check("async_rst_immediate", {btn_level, press_pulse, release_pulse, busy}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    // First edge after release is the first sampling edge; press on the 10th.
    n_edges = 0;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (press_pulse === 1'b1) begin
        seen = 1'b1;
        n_edges = k;
      end
    end
    check("restart_press_seen", {3'b000, seen}, 4'b0001);
    n_vec++;
    if (n_edges != 10) begin
      n_err++;
      $display("FAIL restart_latency got %0d edges want 10", n_edges);
    end
    @(posedge clk);
    #1;
    check("press_one_cycle", {btn_level, press_pulse, release_pulse, busy}, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Press and release strobes must never coincide.
  always @(negedge clk) begin
    if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
      n_err++;
      $display("FAIL pulse_overlap got press=1 release=1 want not both");
    end
  end

endmodule
